// File: rtl/cg_pkg.sv
// cg_pkg: shared types and default parameters for the clock-gate controller.
//   cg_state_e      per-channel gate FSM state (OFF/WAIT/ON/IDLE)
//   CG_*_DEF        default values for the clock_gate_ctrl parameters
package cg_pkg;

  typedef enum logic [1:0] {
    S_OFF  = 2'd0,
    S_WAIT = 2'd1,
    S_ON   = 2'd2,
    S_IDLE = 2'd3
  } cg_state_e;

  localparam int CG_NUM_CLKS_DEF   = 4;
  localparam int CG_IDLE_CNT_W_DEF = 8;
  localparam int CG_STAGGER_DEF    = 2;

endpackage

// File: rtl/cg_channel.sv
// cg_channel: one gated-clock channel -- request FSM plus idle-timeout counter.
// Ports:
//   clk, rst       clock and synchronous active-high reset
//   req            level clock request
//   grant          wake-up grant from the arbiter (only honoured in WAIT)
//   idle_timeout   cycles to linger in IDLE after req falls
//   wait_req       channel is in WAIT and still requesting (arbiter candidate)
//   active         registered: channel is ON or IDLE
//   active_nxt     next-state decode of active (for derived registered enables)
module cg_channel
  import cg_pkg::*;
#(
  parameter int IDLE_CNT_W = CG_IDLE_CNT_W_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req,
  input  logic                  grant,
  input  logic [IDLE_CNT_W-1:0] idle_timeout,
  output logic                  wait_req,
  output logic                  active,
  output logic                  active_nxt
);

  cg_state_e             state_q, state_d;
  logic [IDLE_CNT_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_OFF;
      cnt_q   <= '0;
      active  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      active  <= active_nxt;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_OFF:  if (req) state_d = S_WAIT;
      // A dropped request leaves WAIT without ever being a grant candidate.
      S_WAIT: begin
        if (!req)       state_d = S_OFF;
        else if (grant) state_d = S_ON;
      end
      S_ON: begin
        if (!req) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end
      end
      // Compare before increment: the counter stops at the timeout, never wraps.
      S_IDLE: begin
        if (req)                       state_d = S_ON;
        else if (cnt_q == idle_timeout) state_d = S_OFF;
        else                           cnt_d   = cnt_q + 1'b1;
      end
      default: state_d = S_OFF;
    endcase
  end

  assign wait_req   = (state_q == S_WAIT) && req;
  assign active_nxt = (state_d == S_ON) || (state_d == S_IDLE);

endmodule

// File: rtl/clock_gate.sv
// clock_gate: glitch-free clock gate cell.
// Ports:
//   clk   free-running clock
//   en    enable, launched from the rising edge of clk
//   gclk  gated clock
// BEHAVIORAL_LATCH=0 captures en on the falling edge so it is stable through
// the whole high phase; =1 uses a transparent-low latch (classic ICG model).
module clock_gate #(
  parameter bit BEHAVIORAL_LATCH = 1'b0
) (
  input  logic clk,
  input  logic en,
  output logic gclk
);

  generate
    if (BEHAVIORAL_LATCH) begin : g_latch
      logic en_l;
      always_latch begin
        if (!clk) en_l <= en;
      end
      assign gclk = clk & en_l;
    end else begin : g_flop
      logic en_q;
      always_ff @(negedge clk) en_q <= en;
      assign gclk = clk & en_q;
    end
  endgenerate

endmodule

// File: rtl/clock_gate_ctrl.sv
// clock_gate_ctrl: per-channel clock gating with staggered wake-up.
// Ports:
//   sys_clk_i       clock (rising edge)
//   sys_reset_i     synchronous active-high reset
//   bypass_i        force all enables on (only with CLK_GATE_CTRL_BYPASS_EN)
//   req_i           per-channel clock request (level)
//   idle_timeout_i  cycles a channel stays enabled after its request drops
//   ack_o           per-channel clock-running acknowledge (registered)
//   clk_en_o        per-channel gate enable (registered)
//   gated_clk_o     gated copies of sys_clk_i
// Optional feature macro: CLK_GATE_CTRL_BYPASS_EN.
module clock_gate_ctrl
  import cg_pkg::*;
#(
  parameter int NUM_CLKS       = CG_NUM_CLKS_DEF,
  parameter int IDLE_CNT_W     = CG_IDLE_CNT_W_DEF,
  parameter int STAGGER_CYCLES = CG_STAGGER_DEF
) (
  input  logic                  sys_clk_i,
  input  logic                  sys_reset_i,
`ifdef CLK_GATE_CTRL_BYPASS_EN
  input  logic                  bypass_i,
`endif
  input  logic [NUM_CLKS-1:0]   req_i,
  input  logic [IDLE_CNT_W-1:0] idle_timeout_i,
  output logic [NUM_CLKS-1:0]   ack_o,
  output logic [NUM_CLKS-1:0]   clk_en_o,
  output logic [NUM_CLKS-1:0]   gated_clk_o
);

  localparam int          STG_W    = (STAGGER_CYCLES > 1) ? $clog2(STAGGER_CYCLES) : 1;
  localparam logic [STG_W-1:0] STG_LOAD = STG_W'(STAGGER_CYCLES - 1);

  logic [NUM_CLKS-1:0] wait_req, grant, active, active_nxt;
  logic [STG_W-1:0]    stag_q;

  // Lowest-index WAIT channel wins, and only once the stagger window is over.
  always_comb begin
    grant = '0;
    if (stag_q == '0) begin
      for (int i = 0; i < NUM_CLKS; i++) begin
        if (wait_req[i] && (grant == '0)) grant[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge sys_clk_i) begin
    if (sys_reset_i)           stag_q <= '0;
    else if (|grant)           stag_q <= STG_LOAD;
    else if (stag_q != '0)     stag_q <= stag_q - 1'b1;
  end

  generate
    for (genvar i = 0; i < NUM_CLKS; i++) begin : g_ch
      cg_channel #(
        .IDLE_CNT_W (IDLE_CNT_W)
      ) u_ch (
        .clk          (sys_clk_i),
        .rst          (sys_reset_i),
        .req          (req_i[i]),
        .grant        (grant[i]),
        .idle_timeout (idle_timeout_i),
        .wait_req     (wait_req[i]),
        .active       (active[i]),
        .active_nxt   (active_nxt[i])
      );

      clock_gate #(
        .BEHAVIORAL_LATCH (1'b0)
      ) u_cg (
        .clk  (sys_clk_i),
        .en   (clk_en_o[i]),
        .gclk (gated_clk_o[i])
      );
    end
  endgenerate

  assign ack_o = active;

`ifdef CLK_GATE_CTRL_BYPASS_EN
  // Bypass only overrides the gate enables; the FSMs and ack_o are untouched.
  always_ff @(posedge sys_clk_i) begin
    if (sys_reset_i)   clk_en_o <= '0;
    else if (bypass_i) clk_en_o <= '1;
    else               clk_en_o <= active_nxt;
  end
`else
  assign clk_en_o = active;
`endif

endmodule

// File: tb/tb_clock_gate_ctrl.sv
// Testbench for clock_gate_ctrl: directed scenarios followed by random traffic.
// The driver updates a behavioural model at every falling edge and queues the
// expected outputs; a monitor pops one entry after each rising edge and compares.
module tb_clock_gate_ctrl;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int SC = 2;

  // model state codes (bench-local, independent of the RTL enum)
  localparam int M_OFF  = 0;
  localparam int M_WAIT = 1;
  localparam int M_ON   = 2;
  localparam int M_IDLE = 3;

`ifdef CLK_GATE_CTRL_BYPASS_EN
  localparam bit HAS_BYP = 1'b1;
`else
  localparam bit HAS_BYP = 1'b0;
`endif

  logic          sys_clk_i = 1'b0;
  logic          sys_reset_i;
  logic          bypass_i;
  logic [N-1:0]  req_i;
  logic [W-1:0]  idle_timeout_i;
  logic [N-1:0]  ack_o, clk_en_o, gated_clk_o;

  always #5 sys_clk_i = ~sys_clk_i;

  clock_gate_ctrl #(
    .NUM_CLKS       (N),
    .IDLE_CNT_W     (W),
    .STAGGER_CYCLES (SC)
  ) dut (
    .sys_clk_i      (sys_clk_i),
    .sys_reset_i    (sys_reset_i),
`ifdef CLK_GATE_CTRL_BYPASS_EN
    .bypass_i       (bypass_i),
`endif
    .req_i          (req_i),
    .idle_timeout_i (idle_timeout_i),
    .ack_o          (ack_o),
    .clk_en_o       (clk_en_o),
    .gated_clk_o    (gated_clk_o)
  );

  typedef struct packed {
    logic [N-1:0] ack;
    logic [N-1:0] en;
  } exp_t;

  exp_t sb[$];
  int   m_st [N];
  int   m_cnt[N];
  int   m_stag;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;

  // One cycle of stimulus; the model applies the spec rules for the coming edge.
  task automatic step(input logic rst, input logic [N-1:0] req, input int to, input logic byp);
    int   g;
    exp_t e;
    logic byp_eff;
    @(negedge sys_clk_i);
    byp_eff        = HAS_BYP ? byp : 1'b0;
    sys_reset_i    = rst;
    req_i          = req;
    idle_timeout_i = W'(to);
    bypass_i       = byp_eff;
    g = -1;
    if (!rst && m_stag == 0)
      for (int i = 0; i < N; i++)
        if (g < 0 && m_st[i] == M_WAIT && req[i]) g = i;
    for (int i = 0; i < N; i++) begin
      if (rst) begin
        m_st[i]  = M_OFF;
        m_cnt[i] = 0;
      end else begin
        case (m_st[i])
          M_OFF:  if (req[i]) m_st[i] = M_WAIT;
          M_WAIT: if (!req[i]) m_st[i] = M_OFF; else if (g == i) m_st[i] = M_ON;
          M_ON:   if (!req[i]) begin m_st[i] = M_IDLE; m_cnt[i] = 0; end
          default: begin
            if (req[i])            m_st[i] = M_ON;
            else if (m_cnt[i] == to) m_st[i] = M_OFF;
            else                   m_cnt[i] = m_cnt[i] + 1;
          end
        endcase
      end
    end
    if (rst)         m_stag = 0;
    else if (g >= 0) m_stag = SC - 1;
    else if (m_stag > 0) m_stag = m_stag - 1;
    for (int i = 0; i < N; i++) e.ack[i] = (m_st[i] == M_ON) || (m_st[i] == M_IDLE);
    e.en = rst ? '0 : (byp_eff ? '1 : e.ack);
    sb.push_back(e);
  endtask

  // Monitor: compare after every rising edge; gated clock must track the
  // enable held over the previous cycle, and be low during the low phase.
  initial begin
    exp_t e, prev;
    int   np;
    np = 0;
    prev = '0;
    forever begin
      @(posedge sys_clk_i);
      #1;
      cyc++;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        n_checks++;
        if (ack_o !== e.ack) begin
          n_fail++;
          $display("FAIL ack cyc=%0d got=%b exp=%b", cyc, ack_o, e.ack);
        end
        n_checks++;
        if (clk_en_o !== e.en) begin
          n_fail++;
          $display("FAIL clk_en cyc=%0d got=%b exp=%b", cyc, clk_en_o, e.en);
        end
        if (np >= 2) begin
          n_checks++;
          if (gated_clk_o !== prev.en) begin
            n_fail++;
            $display("FAIL gated_high cyc=%0d got=%b exp=%b", cyc, gated_clk_o, prev.en);
          end
        end
        prev = e;
        np++;
        @(negedge sys_clk_i);
        #1;
        n_checks++;
        if (gated_clk_o !== '0) begin
          n_fail++;
          $display("FAIL gated_low cyc=%0d got=%b exp=0000", cyc, gated_clk_o);
        end
      end
    end
  end

  initial begin
    logic [N-1:0] r;
    sys_reset_i    = 1'b1;
    req_i          = '0;
    idle_timeout_i = '0;
    bypass_i       = 1'b0;
    for (int i = 0; i < N; i++) begin m_st[i] = M_OFF; m_cnt[i] = 0; end
    m_stag = 0;

    repeat (3) step(1'b1, 4'b0000, 0, 1'b0);
    // single request: ack two edges later
    step(1'b0, 4'b0000, 3, 1'b0);
    repeat (6) step(1'b0, 4'b0001, 3, 1'b0);
    // ch0 drop with timeout 3, reassert after 2 cycles, then let it time out
    repeat (2) step(1'b0, 4'b0000, 3, 1'b0);
    repeat (3) step(1'b0, 4'b0001, 3, 1'b0);
    repeat (8) step(1'b0, 4'b0000, 3, 1'b0);
    // timeout 0: exactly one IDLE cycle
    repeat (4) step(1'b0, 4'b0100, 0, 1'b0);
    repeat (4) step(1'b0, 4'b0000, 0, 1'b0);
    // all channels at once: staggered wake-up, then reset with all ON
    repeat (12) step(1'b0, 4'b1111, 2, 1'b0);
    step(1'b1, 4'b1111, 2, 1'b0);
    repeat (4) step(1'b0, 4'b0000, 2, 1'b0);
    // ch1 one-cycle pulse while ch0 holds the stagger slot, ch2 follows
    step(1'b0, 4'b0001, 2, 1'b0);
    step(1'b0, 4'b0011, 2, 1'b0);
    step(1'b0, 4'b0101, 2, 1'b0);
    repeat (6) step(1'b0, 4'b0101, 2, 1'b0);
    // reset in the middle of WAIT
    step(1'b0, 4'b1010, 2, 1'b0);
    step(1'b1, 4'b1010, 2, 1'b0);
    repeat (3) step(1'b0, 4'b0000, 2, 1'b0);
    // bypass (only meaningful when the feature is built in)
    repeat (3) step(1'b0, 4'b0000, 0, 1'b1);
    repeat (2) step(1'b0, 4'b0000, 0, 1'b0);

    r = '0;
    for (int k = 0; k < 1500; k++) begin
      for (int i = 0; i < N; i++)
        if ($urandom_range(5) == 0) r[i] = ~r[i];
      step(($urandom_range(199) == 0), r, $urandom_range(5), ($urandom_range(9) == 0));
    end
    repeat (2) step(1'b0, 4'b0000, 0, 1'b0);

    repeat (3) @(posedge sys_clk_i);
    #3;
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL drain got=%0d exp=0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/clock_gate_ctrl.md
CLOCK_GATE_CTRL -- requirements
Module: clock_gate_ctrl

Interface
REQ-001 SHALL have parameter NUM_CLKS, default 4, number of gated clock channels (1..32).
REQ-002 SHALL have parameter IDLE_CNT_W, default 8, width of idle-timeout counter and timeout input.
REQ-003 SHALL have parameter STAGGER_CYCLES, default 2, minimum cycles between successive channel wake-ups (>=1).
REQ-004 SHALL have port sys_clk_i  input  1  the single clock; all logic is on its rising edge.
REQ-005 SHALL have port sys_reset_i  input  1  reset, synchronous and active-high.
REQ-006 SHALL have port req_i  input  NUM_CLKS  per-channel clock request, level.
REQ-007 SHALL have port idle_timeout_i  input  IDLE_CNT_W  cycles a channel stays enabled after req_i falls.
REQ-008 SHALL have port ack_o  output  NUM_CLKS  per-channel clock-running acknowledge.
REQ-009 SHALL have port clk_en_o  output  NUM_CLKS  registered per-channel gate enable.
REQ-010 SHALL have port gated_clk_o  output  NUM_CLKS  gated copies of sys_clk_i.

Function
REQ-011 Each channel SHALL run an FSM with states OFF, WAIT, ON, IDLE.
REQ-012 OFF: req_i=1 -> WAIT next cycle; otherwise stay.
REQ-013 WAIT: req_i=0 -> OFF without consuming a wake-up slot; granted -> ON; else stay.
REQ-014 ON: req_i=0 -> IDLE with idle counter loaded to 0; else stay.
REQ-015 IDLE: req_i=1 -> ON; counter == idle_timeout_i -> OFF; else counter +1.
REQ-016 idle_timeout_i=0 SHALL give exactly one IDLE cycle before OFF; the counter SHALL never wrap, since comparison precedes increment.
REQ-017 clk_en_o[i] and ack_o[i] SHALL be 1 exactly when channel i is in ON or IDLE; both are registered state decodes.
REQ-018 Wake-up arbiter SHALL grant at most one WAIT channel per cycle, lowest index first, and only when the stagger counter is 0.
REQ-019 On grant, the stagger counter SHALL load STAGGER_CYCLES-1, then decrement to 0 and saturate there.
REQ-020 Minimum latency: req_i rises in cycle t -> WAIT at t+1 -> ack_o/clk_en_o high at t+2.
REQ-021 Simultaneous requests SHALL be granted in index order, spaced STAGGER_CYCLES cycles apart.
REQ-022 IDLE->ON and ON->IDLE SHALL need no grant and SHALL not affect the stagger counter.
REQ-023 gated_clk_o[i] SHALL come from one clock_gate instance per channel (BEHAVIORAL_LATCH=0) driven by clk_en_o[i], so gating is glitch-free.
REQ-024 idle_timeout_i SHALL be sampled on each cycle of the comparison; changing it mid-IDLE takes effect on the next comparison.

Reset
REQ-025 On sys_reset_i=1 at a rising edge, every FSM SHALL go to OFF, idle counters and stagger counter to 0, and ack_o and clk_en_o to 0.
REQ-026 Reset asserted mid-operation SHALL abort WAIT, ON and IDLE alike, with no partial grants retained.
REQ-027 gated_clk_o SHALL be held low from the cycle after clk_en_o clears.

Configuration
REQ-028 With macro CLK_GATE_CTRL_BYPASS_EN defined, the module SHALL add input bypass_i (1 bit).
REQ-029 With that macro defined and bypass_i=1, clk_en_o SHALL be all ones (registered, one-cycle latency); FSMs and ack_o SHALL behave unchanged.
REQ-030 Without the macro, the module SHALL have no bypass_i port and no bypass logic.

Structure
REQ-031 Package cg_pkg SHALL hold the channel state enum typedef (OFF/WAIT/ON/IDLE) and the default parameter constants.
REQ-032 The per-channel FSM and idle counter SHALL live in sub-module cg_channel; arbiter, stagger counter and clock_gate instances stay in clock_gate_ctrl.

Verification
REQ-033 NUM_CLKS=4, STAGGER_CYCLES=2: req_i 0000->0001 at t -> ack_o[0]=1 at t+2, clk_en_o=0001.
REQ-034 req_i 0000->1111 at t -> ack_o bits rise in order 0,1,2,3 at t+2, t+4, t+6, t+8.
REQ-035 idle_timeout_i=3, ch0 ON, req_i[0] falls at t -> IDLE t+1..t+4, OFF and clk_en_o[0]=0 at t+5; reassert at t+2 -> ON at t+3, stays enabled.
REQ-036 req_i[1] pulse of 1 cycle while ch0 holds the stagger slot -> ch1 returns WAIT->OFF, ack_o[1] never 1, next requester is not delayed.
REQ-037 sys_reset_i=1 for 1 cycle with all channels ON -> ack_o=clk_en_o=0000 next cycle, gated_clk_o flat low afterwards.
REQ-038 With CLK_GATE_CTRL_BYPASS_EN, bypass_i=1, req_i=0 -> clk_en_o=1111 next cycle, ack_o=0000.
